// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator: command op codes, command-input
// FSM states and the switch decode used to build a command.
package rpn_pkg;

    // Op codes understood by the rpn core.
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } rpn_op_e;

    // Command-input FSM states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_VALID    = 2'b01,
        S_WAIT_REL = 2'b10
    } cmd_in_state_e;

    localparam int SW_W        = 10;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    // Operator select codes on sw[9:8]; sw[9] is add, sw[8] is subtract.
    localparam logic [1:0] SEL_PUSH = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_SUB  = 2'b01;

    // Result of decoding the switches at the moment of a key press.
    typedef struct packed {
        logic              legal;
        rpn_op_e           op;
        logic [DATA_W-1:0] data;
    } cmd_decode_t;

    // Map the switch bank onto a command; both operator switches up is reserved.
    function automatic cmd_decode_t decode_sw(input logic [SW_W-1:0] sw_val);
        cmd_decode_t d;
        d.legal = 1'b1;
        d.op    = OP_PUSH;
        d.data  = '0;
        case (sw_val[9:8])
            SEL_PUSH: d.data  = sw_val[DATA_W-1:0];
            SEL_ADD:  d.op    = OP_ADD;
            SEL_SUB:  d.op    = OP_SUB;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rpn_debounce.sv
// Key conditioner: two-flop synchronizer followed by a counting debouncer.
// Produces the debounced (active-low) key level and a one-cycle press pulse
// on every debounced 1->0 transition.
module rpn_debounce
    import rpn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that would take the counter to DEBOUNCE_CYCLES flips the
    // level instead, so the counter never actually holds that value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES:0] sync_chain;
    logic                 sync_key;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 level_reg;
    logic                 press_reg;

    assign sync_chain[0] = key_n;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            // One synchronizer stage; resets to the released (high) level.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_reg <= 1'b1;
                end else begin
                    stage_reg <= sync_chain[gi];
                end
            end
            assign sync_chain[gi+1] = stage_reg;
        end
    endgenerate

    assign sync_key = sync_chain[SYNC_STAGES];

    // Count disagreeing samples; flip the level after DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (sync_key == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= sync_key;
                press_reg <= ~sync_key;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/rpn_cmd_in.sv
// Command front end of the RPN calculator: turns a debounced ENTER key press
// plus the slide switches into a single valid/ready command for the core.
// One press yields one command; a reserved operator code sets a sticky error.
module rpn_cmd_in
    import rpn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       key_enter_n,
    input  logic [9:0] sw,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    output logic       cmd_err
);

    logic          key_level;
    logic          key_press;
    cmd_decode_t   dec;

    cmd_in_state_e     state_reg;
    logic              valid_reg;
    rpn_op_e           op_reg;
    logic [DATA_W-1:0] data_reg;
    logic              err_reg;

    rpn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_n (key_enter_n),
        .level (key_level),
        .press (key_press)
    );

    // Switches are quasi-static, so they are decoded directly on the press edge.
    assign dec = decode_sw(sw);

    // Command FSM with registered outputs; op/data only change on capture.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            valid_reg <= 1'b0;
            op_reg    <= OP_PUSH;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (key_press) begin
                        if (dec.legal) begin
                            op_reg    <= dec.op;
                            data_reg  <= dec.data;
                            valid_reg <= 1'b1;
                            state_reg <= S_VALID;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= S_WAIT_REL;
                        end
                    end
                end
                S_VALID: begin
                    // Presses seen here are dropped: only the handshake leaves.
                    if (cmd_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= key_level ? S_IDLE : S_WAIT_REL;
                    end
                end
                S_WAIT_REL: begin
                    if (key_level) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid = valid_reg;
    assign cmd_op    = op_reg;
    assign cmd_data  = data_reg;
    assign cmd_err   = err_reg;

endmodule

// File: tb/tb_rpn_cmd_in.sv
// Directed bench for rpn_cmd_in with DEBOUNCE_CYCLES=4. Expected commands are
// queued when a press is driven and checked when the handshake is observed.
module tb_rpn_cmd_in;
    import rpn_pkg::*;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic       key_enter_n;
    logic [9:0] sw;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_err;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   hs_count  = 0;

    rpn_cmd_in #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .key_enter_n (key_enter_n),
        .sw          (sw),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Handshake monitor at the falling edge: pops and checks the scoreboard.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            hs_count++;
            $display("cmd %0d: op=%0d data=%02h err=%0b", hs_count, cmd_op, cmd_data, cmd_err);
            check("cmd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("cmd_op", cmd_op, mon_e.op);
                check("cmd_data", cmd_data, mon_e.data);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        key_enter_n = 1'b0;
        sw          = 10'h000;
        cmd_ready   = 1'b0;

        // Reset held with the key low: outputs stay quiet.
        tick(1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("rst_valid", cmd_valid, 0);
            check("rst_err", cmd_err, 0);
            check("rst_data", cmd_data, 8'h00);
        end
        check("rst_op", cmd_op, OP_PUSH);
        rst_n       = 1'b1;
        key_enter_n = 1'b1;
        tick(4);
        $display("step: reset done");

        // PUSH A9 with ready high: one-cycle valid pulse after edge k+6.
        sw          = 10'h0A9;
        cmd_ready   = 1'b1;
        key_enter_n = 1'b0;
        exp_q.push_back('{op: OP_PUSH, data: 8'hA9});
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check($sformatf("push_valid_t%0d", i), cmd_valid, (i == DB + 3) ? 1 : 0);
        end
        key_enter_n = 1'b1;
        tick(10);
        check("push_hs_count", hs_count, 1);
        $display("step: push A9 done");

        // Short bounces (3 low, 1 high) never reach the debounce threshold.
        cmd_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            key_enter_n = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                check("bounce_valid", cmd_valid, 0);
            end
            key_enter_n = 1'b1;
            tick(1);
            check("bounce_valid", cmd_valid, 0);
        end
        tick(8);
        check("bounce_hs_count", hs_count, 1);
        $display("step: bounce done");

        // ADD with ready low: command held stable while switches change.
        sw          = 10'h200;
        cmd_ready   = 1'b0;
        key_enter_n = 1'b0;
        exp_q.push_back('{op: OP_ADD, data: 8'h00});
        tick(DB + 2);
        check("add_valid_early", cmd_valid, 0);
        tick(1);
        check("add_valid", cmd_valid, 1);
        sw = 10'h05B;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("add_hold_valid", cmd_valid, 1);
            check("add_hold_op", cmd_op, OP_ADD);
            check("add_hold_data", cmd_data, 8'h00);
        end
        cmd_ready = 1'b1;
        tick(1);
        check("add_valid_drop", cmd_valid, 0);
        key_enter_n = 1'b1;
        tick(10);
        check("add_hs_count", hs_count, 2);
        $display("step: add done");

        // Reserved code sets the sticky error; a later SUB still goes out.
        sw          = 10'h300;
        key_enter_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("rsvd_valid", cmd_valid, 0);
        end
        check("rsvd_err", cmd_err, 1);
        key_enter_n = 1'b1;
        tick(10);
        sw          = 10'h100;
        key_enter_n = 1'b0;
        exp_q.push_back('{op: OP_SUB, data: 8'h00});
        tick(DB + 3);
        check("sub_valid", cmd_valid, 1);
        check("sub_err_sticky", cmd_err, 1);
        tick(1);
        check("sub_valid_drop", cmd_valid, 0);
        key_enter_n = 1'b1;
        tick(10);
        check("sub_hs_count", hs_count, 3);
        $display("step: reserved/sub done");

        // Reset in S_VALID drops the command; held key re-debounces afterwards.
        sw          = 10'h010;
        cmd_ready   = 1'b0;
        key_enter_n = 1'b0;
        exp_q.push_back('{op: OP_PUSH, data: 8'h10});
        tick(DB + 3);
        check("pre_rst_valid", cmd_valid, 1);
        check("pre_rst_data", cmd_data, 8'h10);
        rst_n = 1'b0;
        tick(1);
        exp_q.delete();
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_data", cmd_data, 8'h00);
        check("mid_rst_err", cmd_err, 0);
        rst_n = 1'b1;
        exp_q.push_back('{op: OP_PUSH, data: 8'h10});
        tick(DB + 2);
        check("post_rst_valid_early", cmd_valid, 0);
        tick(1);
        check("post_rst_valid", cmd_valid, 1);
        check("post_rst_op", cmd_op, OP_PUSH);
        check("post_rst_data", cmd_data, 8'h10);
        cmd_ready = 1'b1;
        tick(1);
        check("post_rst_valid_drop", cmd_valid, 0);
        key_enter_n = 1'b1;
        tick(10);
        $display("step: reset during valid done");

        check("final_hs_count", hs_count, 4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
